// File: rtl/traffic_phase_scheduler_if.sv
// Signal bundle between the traffic controller environment and the phase scheduler.
// The master drives the timebase, sensors and requests; the slave drives the lamps and status.
interface traffic_phase_scheduler_if;
  logic       tick;
  logic [1:0] Sa;
  logic [1:0] Sb;
  logic [1:0] Sc;
  logic [1:0] Sd;
  logic [3:0] ped_req;
  logic [3:0] emerg;
  logic [2:0] Ta;
  logic [2:0] Tb;
  logic [2:0] Tc;
  logic [2:0] Td;
  logic [3:0] walk;
  logic [3:0] ped_pend;
  logic [1:0] phase;

  modport master (
    output tick, Sa, Sb, Sc, Sd, ped_req, emerg,
    input  Ta, Tb, Tc, Td, walk, ped_pend, phase
  );

  modport slave (
    input  tick, Sa, Sb, Sc, Sd, ped_req, emerg,
    output Ta, Tb, Tc, Td, walk, ped_pend, phase
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Self-timed four-approach phase scheduler: picks the green side from demand, pedestrian
// requests and emergency preemption, and sequences it through green, orange and all-red.
module traffic_phase_scheduler #(
  parameter int unsigned MIN_GREEN = 10,
  parameter int unsigned MAX_GREEN = 30,
  parameter int unsigned ORANGE_T  = 3,
  parameter int unsigned ALLRED_T  = 2
) (
  input logic                     clk,
  input logic                     rst,
  traffic_phase_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    ORANGE = 2'd1,
    ALLRED = 2'd2
  } state_t;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_ORANGE = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [4:0] ORANGE_LOAD = 5'(ORANGE_T - 1);
  localparam logic [4:0] ALLRED_LOAD = 5'(ALLRED_T - 1);
  localparam logic [5:0] MIN_LIM     = 6'(MIN_GREEN);
  localparam logic [5:0] MAX_LIM     = 6'(MAX_GREEN);

  state_t          state_q, state_d;
  logic [4:0]      timer_q, timer_d;
  logic [4:0]      gcnt_q, gcnt_d;
  logic [1:0]      phase_q, phase_d;
  logic [3:0]      ped_pend_q, ped_pend_d;
  logic [3:0]      walk_q, walk_d;
  logic [3:0][2:0] lamp_q, lamp_d;

  logic [3:0][1:0] sensor;
  logic [3:0][2:0] demand;
  logic [3:0]      phase_mask;
  logic [3:0]      sel_mask;
  logic [1:0]      sel;
  logic [5:0]      gcnt_next;
  logic            phase_is_max;
  logic            green_exit;

  assign sensor     = {bus.Sd, bus.Sc, bus.Sb, bus.Sa};
  assign phase_mask = 4'b0001 << phase_q;
  assign sel_mask   = 4'b0001 << sel;
  // Six bits so a saturated count of 31 still compares correctly against the limits.
  assign gcnt_next  = {1'b0, gcnt_q} + 6'd1;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      demand[i] = {1'b0, sensor[i]} + {2'b00, ped_pend_q[i]};
    end
  end

  // Emergency picks the lowest set side; otherwise highest demand, ties resolved by
  // searching phase+1 .. phase so the first strictly-greater candidate wins.
  always_comb begin
    logic [2:0] best;
    logic       found;
    logic [1:0] idx;
    sel   = phase_q + 2'd1;
    best  = '0;
    found = 1'b0;
    idx   = '0;
    if (|bus.emerg) begin
      for (int i = 3; i >= 0; i--) begin
        if (bus.emerg[i]) sel = 2'(i);
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        idx = phase_q + 2'(k);
        if (!found || demand[idx] > best) begin
          sel   = idx;
          best  = demand[idx];
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    phase_is_max = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) != phase_q && demand[i] >= demand[phase_q]) phase_is_max = 1'b0;
    end
  end

  always_comb begin
    green_exit = 1'b0;
    if ((|(bus.emerg & ~phase_mask)) && !bus.emerg[phase_q]) begin
      green_exit = 1'b1;
    end else if (bus.emerg[phase_q]) begin
      green_exit = 1'b0;
    end else if (gcnt_next < MIN_LIM) begin
      green_exit = 1'b0;
    end else if (gcnt_next >= MAX_LIM || !phase_is_max) begin
      green_exit = 1'b1;
    end
  end

  function automatic logic [2:0] lamp_code(input state_t s);
    case (s)
      GREEN:   return LAMP_GREEN;
      ORANGE:  return LAMP_ORANGE;
      default: return LAMP_RED;
    endcase
  endfunction

  // NOTE: every signal driven here gets its default first, so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    gcnt_d     = gcnt_q;
    phase_d    = phase_q;
    walk_d     = walk_q;
    ped_pend_d = ped_pend_q | (bus.ped_req & ((state_q == GREEN) ? ~phase_mask : 4'b1111));

    if (bus.tick) begin
      case (state_q)
        GREEN: begin
          if (green_exit) begin
            state_d = ORANGE;
            timer_d = ORANGE_LOAD;
            walk_d  = '0;
          end else begin
            gcnt_d = (gcnt_q == 5'd31) ? gcnt_q : gcnt_q + 5'd1;
          end
        end
        ORANGE: begin
          if (timer_q == '0) begin
            state_d = ALLRED;
            timer_d = ALLRED_LOAD;
          end else begin
            timer_d = timer_q - 5'd1;
          end
        end
        ALLRED: begin
          if (timer_q == '0) begin
            state_d    = GREEN;
            phase_d    = sel;
            gcnt_d     = '0;
            // A request landing on the entry edge is served by this green, not left pending.
            walk_d     = (ped_pend_q | bus.ped_req) & sel_mask;
            ped_pend_d = ped_pend_d & ~sel_mask;
          end else begin
            timer_d = timer_q - 5'd1;
          end
        end
        default: begin
          state_d = ALLRED;
          timer_d = ALLRED_LOAD;
        end
      endcase
    end

    for (int i = 0; i < 4; i++) begin
      lamp_d[i] = (2'(i) == phase_d) ? lamp_code(state_d) : LAMP_RED;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ALLRED;
      timer_q    <= ALLRED_LOAD;
      gcnt_q     <= '0;
      phase_q    <= 2'd3;
      ped_pend_q <= '0;
      walk_q     <= '0;
      lamp_q     <= {4{LAMP_RED}};
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      gcnt_q     <= gcnt_d;
      phase_q    <= phase_d;
      ped_pend_q <= ped_pend_d;
      walk_q     <= walk_d;
      lamp_q     <= lamp_d;
    end
  end

  assign bus.Ta       = lamp_q[0];
  assign bus.Tb       = lamp_q[1];
  assign bus.Tc       = lamp_q[2];
  assign bus.Td       = lamp_q[3];
  assign bus.walk     = walk_q;
  assign bus.ped_pend = ped_pend_q;
  assign bus.phase    = phase_q;

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Self-timed phase scheduler for a four-approach intersection. It picks which approach gets green using sensor demand, latched pedestrian requests and emergency preemption. It sequences each phase through green, orange and an all-red clearance, driving the same one-hot lamp encoding as the rest of the traffic design. It owns its phase timer, so no external counter is needed.

## Interface
Parameters:
- MIN_GREEN, 10: minimum green length in ticks (1..31).
- MAX_GREEN, 30: maximum green length in ticks without emergency (MIN_GREEN..31).
- ORANGE_T, 3: orange length in ticks (1..31).
- ALLRED_T, 2: all-red clearance length in ticks (1..31).

Ports:
- clk, input, 1: the single clock.
- rst, input, 1: asynchronous, active-high reset.
- tick, input, 1: timebase enable; all timing advances only in cycles with tick=1.
- Sa, Sb, Sc, Sd, input, 2 each: traffic sensor levels, 0..3.
- ped_req, input, 4: single-cycle pedestrian request pulses; bit i is side i (0=A … 3=D).
- emerg, input, 4: level emergency-preempt requests, one bit per side.
- Ta, Tb, Tc, Td, output, 3 each: lamps; 001 green, 010 orange, 100 red.
- walk, output, 4: pedestrian walk; bit i high for the whole green of side i, if granted.
- ped_pend, output, 4: latched pending pedestrian requests.
- phase, output, 2: currently selected side.

## Operation
- State machine: GREEN, ORANGE, ALLRED. It cycles GREEN → ORANGE → ALLRED → GREEN, always on the selected side `phase`.
- Timer: 5-bit. On entering a timed state it loads duration-1. Each tick it decrements. ORANGE and ALLRED exit on a tick with timer==0, so each lasts exactly ORANGE_T / ALLRED_T ticks.
- Green counter (gcnt, 5-bit):
  - Cleared on entering GREEN.
  - Incremented each GREEN tick, saturating at 31.
- GREEN exit test, evaluated on every tick while in GREEN, using gcnt before the increment:
  - emerg has a bit set for a side other than `phase`, and emerg[phase]=0: go to ORANGE on this tick, ignoring MIN_GREEN.
  - Else, if emerg[phase]=1: stay in GREEN, with no MAX_GREEN limit.
  - Else, if gcnt+1 < MIN_GREEN: stay.
  - Else, if gcnt+1 ≥ MAX_GREEN, or `phase` is not the strict maximum of effective demand: go to ORANGE.
  - Else: stay.
- Effective demand, side i: 3-bit value {0,Si} + ped_pend[i]. No overflow is possible (maximum is 4).
- Selection happens on the ALLRED exit tick; the result is registered into `phase` on the same edge that enters GREEN.
  - If any emerg bit is set, the lowest-index set bit wins.
  - Else the maximum effective demand wins.
  - Ties are broken round-robin, searching phase+1, phase+2, phase+3, phase (mod 4). All-zero demand therefore rotates to phase+1.
- Pedestrian handling:
  - ped_pend[i] is set by ped_req[i]. It is not set when side i is currently in GREEN; that request is already served.
  - ped_pend[i] is cleared on entry to GREEN for side i.
  - walk[i] = ped_pend[i] captured at that entry, held through the whole green, and low during ORANGE and ALLRED.
  - If a pulse arrives on the entry edge itself, clear wins and walk is granted.
- tick=0: no state, timer or gcnt change. ped_pend still latches requests.
- Lamps:
  - The side equal to `phase` shows 001 in GREEN, 010 in ORANGE, 100 in ALLRED.
  - All other sides always show 100.

## Timing
- All outputs are registered and change on the clk edge where the state changes; there is no combinational input-to-output path.
- Selection latency: inputs are sampled on the ALLRED exit tick edge, and lamps show green on that same edge.
- Reset values (asynchronous, immediate, including mid-phase):
  - State ALLRED, timer ALLRED_T-1, phase=3, gcnt=0.
  - ped_pend=0, walk=0, all lamps 100.
  - The first selection after reset therefore starts its tie search at side A.
- Emergency abort: orange appears on the edge of the first tick on which the preempt condition is seen.

## Test plan
- Reset, tick=1, all inputs 0: all red for 2 cycles, then Ta=001 for 10 cycles, Ta=010 for 3, all red for 2, then Tb=001.
- Sa=3, others 0: A green for exactly 30 ticks, orange 3, all-red 2, then A re-selected (phase=0).
- After A, Sb=Sc=2 and Sd=0: B is selected; on the next round with the same inputs, C is selected (round-robin tie).
- emerg[3] rises on the 3rd tick of A green: Ta=010 on the next edge, then all-red; D gets green and holds past 30 ticks while emerg[3]=1; after it drops, D leaves green on the next tick (gcnt≥30).
- ped_req[2] pulse during A green, sensors all 0: ped_pend=0100; next selection is C; walk=0100 for the whole C green; ped_pend returns to 0 on C green entry.
- tick=0 for 20 cycles mid-green: outputs frozen. Async rst pulse mid-orange: lamps all 100 immediately, ped_pend=0, sequence restarts as in the first scenario.
